// File: rtl/read_arb_pkg.sv
// Shared constants for the slow-port read arbiter: default sizing, FSM encoding
// and a round-robin helper.
package read_arb_pkg;

    // Default sizing.
    localparam int unsigned DefNreq    = 4;
    localparam int unsigned DefAw      = 16;
    localparam int unsigned DefDw      = 32;
    localparam int unsigned DefTimeout = 255;

    // Controller state encoding.
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    // Index following idx in a ring of n entries.
    function automatic logic [31:0] rr_next(input logic [31:0] idx, input int unsigned n);
        logic [31:0] nxt;
        nxt = idx + 32'd1;
        if (nxt >= n) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
    input  logic clk100,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state of the two-stage chain.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Chain registers, cleared by the synchronous reset.
    always_ff @(posedge clk100) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/read_arbiter.sv
// Round-robin arbiter sharing one slow-domain read port between NREQ requesters.
// The slow side answers with a 4-phase read_f/ack_s handshake; ack_s is
// synchronized before use and a per-transaction timeout bounds the wait.
module read_arbiter
    import read_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DefNreq,
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                 clk100,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    output logic [NREQ-1:0]      ack_o,
    output logic                 err_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 read_f,
    output logic [AW-1:0]        addr_f,
    input  logic                 ack_s,
    input  logic [DW-1:0]        rdata_s
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = 16;
    localparam logic [CntW:0] TimeoutVal = (CntW + 1)'(TIMEOUT);

    logic              ack_q;

    logic [1:0]        state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              read_f_q, read_f_d;
    logic [AW-1:0]     addr_f_q, addr_f_d;
    // Blocks grants for two cycles after reset so the synchronizer reflects
    // the real ack_s level before IDLE trusts ack_q=0.
    logic [1:0]        rst_hold_q, rst_hold_d;

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [AW-1:0]     win_addr;
    logic [31:0]       rr_pos;
    logic [CntW:0]     cnt_inc;

    sync2 u_ack_sync (
        .clk100 (clk100),
        .reset  (reset),
        .d_i    (ack_s),
        .q_o    (ack_q)
    );

    // Round-robin search for the first active request at or after ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_pos    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_pos = 32'(ptr_q) + i;
            if (rr_pos >= NREQ) begin
                rr_pos = rr_pos - NREQ;
            end
            if (!win_found && req_i[rr_pos[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_pos[IdxW-1:0];
            end
        end
        win_addr = addr_i[32'(win_idx) * AW +: AW];
    end

    // Transaction controller next-state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        read_f_d   = read_f_q;
        addr_f_d   = addr_f_q;
        rst_hold_d = {1'b0, rst_hold_q[1]};
        cnt_inc    = {1'b0, cnt_q} + 1'b1;

        case (state_q)
            StIdle: begin
                // A high ack_q here is a leftover (late or post-reset) ack; wait it out.
                if (win_found && !ack_q && (rst_hold_q == 2'b00)) begin
                    state_d  = StReq;
                    read_f_d = 1'b1;
                    addr_f_d = win_addr;
                    gnt_d    = win_idx;
                    ptr_d    = IdxW'(rr_next(32'(win_idx), NREQ));
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end
            end
            StReq: begin
                cnt_d = cnt_inc[CntW-1:0];
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (ack_q) begin
                    rdata_d  = rdata_s;
                    err_d    = 1'b0;
                    read_f_d = 1'b0;
                    state_d  = StDone;
                end else if (cnt_inc == TimeoutVal) begin
                    err_d    = 1'b1;
                    read_f_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!ack_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                read_f_d = 1'b0;
            end
        endcase
    end

    // Controller registers with synchronous active-high reset.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            read_f_q   <= 1'b0;
            addr_f_q   <= '0;
            rst_hold_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            read_f_q   <= read_f_d;
            addr_f_q   <= addr_f_d;
            rst_hold_q <= rst_hold_d;
        end
    end

    // Completion pulse is a decode of the one-cycle DONE state.
    always_comb begin
        ack_o = '0;
        err_o = 1'b0;
        if (state_q == StDone) begin
            ack_o[gnt_q] = 1'b1;
            err_o        = err_q;
        end
    end

    assign rdata_o = rdata_q;
    assign read_f  = read_f_q;
    assign addr_f  = addr_f_q;

endmodule
